// File: rtl/arm_position_writer_pkg.sv
// Shared constants for the arm position frame writer: frame header, coordinate
// limit, rejection codes and FSM state encoding.
package arm_position_writer_pkg;

    localparam logic [7:0] HEADER_BYTE       = 8'hA5;
    localparam int unsigned MAX_COORD_VALUE = 999;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_CHECKSUM = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_FULL     = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    // True when any of the packed x/y/z fields exceeds the display limit.
    function automatic logic coord_over(input logic [29:0] word, input int unsigned max_coord);
        return (32'(word[29:20]) > max_coord) ||
               (32'(word[19:10]) > max_coord) ||
               (32'(word[9:0])   > max_coord);
    endfunction

endpackage

// File: rtl/position_ram.sv
// Simple dual-port position store: one write port, one registered read port.
// Only the read register is reset; the array itself keeps its contents.
module position_ram #(
    parameter int DATA_WIDTH    = 30,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-before-write: a same-address collision returns the old word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/arm_position_writer.sv
// Parses HEADER/B1..B4/CHK byte frames into packed x/y/z position words and
// appends validated words to a non-wrapping position memory.
module arm_position_writer
    import arm_position_writer_pkg::*;
#(
    parameter int          DATA_WIDTH    = 30,
    parameter int          ADDRESS_WIDTH = 4,
    parameter logic [7:0]  HEADER        = HEADER_BYTE,
    parameter int unsigned MAX_COORD     = MAX_COORD_VALUE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     frame_ok,
    output logic                     frame_err,
    output logic [1:0]               err_code,
    output logic [ADDRESS_WIDTH:0]   wr_count,
    output logic                     full
);

    localparam logic [ADDRESS_WIDTH:0] DEPTH = (ADDRESS_WIDTH+1)'(1) << ADDRESS_WIDTH;

    logic [1:0]             state_reg;
    logic [1:0]             idx_reg;
    logic [31:0]            shift_reg;
    logic [7:0]             chk_reg;
    logic [1:0]             err_code_reg;
    logic [ADDRESS_WIDTH:0] wr_count_reg;

    logic                   xfer;
    logic                   in_commit;
    logic [7:0]             checksum;
    logic [1:0]             commit_err;

    assign byte_ready = (state_reg != ST_COMMIT);
    assign xfer       = byte_valid && byte_ready;
    assign in_commit  = (state_reg == ST_COMMIT);
    assign full       = (wr_count_reg == DEPTH);
    assign wr_count   = wr_count_reg;
    assign err_code   = err_code_reg;

    // Checksum covers the full B1 byte even though its top two bits are dropped.
    assign checksum = shift_reg[31:24] ^ shift_reg[23:16] ^ shift_reg[15:8] ^ shift_reg[7:0];

    always_comb begin
        commit_err = ERR_NONE;
        if (chk_reg != checksum) begin
            commit_err = ERR_CHECKSUM;
        end else if (coord_over(shift_reg[29:0], MAX_COORD)) begin
            commit_err = ERR_RANGE;
        end else if (full) begin
            commit_err = ERR_FULL;
        end
    end

    assign frame_ok  = in_commit && (commit_err == ERR_NONE);
    assign frame_err = in_commit && (commit_err != ERR_NONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            shift_reg    <= '0;
            chk_reg      <= '0;
            err_code_reg <= ERR_NONE;
            wr_count_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (xfer && byte_in == HEADER) begin
                        state_reg <= ST_DATA;
                        idx_reg   <= '0;
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        shift_reg <= {shift_reg[23:0], byte_in};
                        idx_reg   <= idx_reg + 2'd1;
                        if (idx_reg == 2'd3) begin
                            state_reg <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (xfer) begin
                        chk_reg   <= byte_in;
                        state_reg <= ST_COMMIT;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    if (frame_ok) begin
                        wr_count_reg <= wr_count_reg + 1'b1;
                    end
                    if (frame_err) begin
                        err_code_reg <= commit_err;
                    end
                end
            endcase
        end
    end

    // The write pointer is the entry count; writes stop once full, so it never wraps.
    position_ram #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_position_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (frame_ok),
        .wr_addr (wr_count_reg[ADDRESS_WIDTH-1:0]),
        .wr_data (shift_reg[DATA_WIDTH-1:0]),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_arm_position_writer.sv
// Directed bench for arm_position_writer: good, bad-checksum, out-of-range,
// full-memory, mid-frame reset and gapped/junk-prefixed frames.
module tb_arm_position_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [3:0]  rd_addr;
    logic [29:0] rd_data;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [4:0]  wr_count;
    logic        full;

    int errors = 0;
    int checks = 0;
    int ready_low = 0;
    int ready_base;

    always #5 clk = ~clk;

    arm_position_writer dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .wr_count   (wr_count),
        .full       (full)
    );

    always @(negedge clk) begin
        if (!byte_ready) ready_low <= ready_low + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited;
        byte_in    = b;
        byte_valid = 1'b1;
        waited     = 0;
        while (!byte_ready && waited < 8) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!byte_ready) begin
            errors++;
            $display("FAIL ready_timeout: byte_ready stayed low for %0d cycles", waited);
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    // Sends a full frame, then checks the COMMIT cycle and the settled state after it.
    task automatic send_frame(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                              input logic [7:0] b4, input logic [7:0] chk, input int gap,
                              input logic exp_ok, input logic [1:0] exp_code, input logic [4:0] exp_count);
        send_byte(8'hA5); idle(gap);
        send_byte(b1);    idle(gap);
        send_byte(b2);    idle(gap);
        send_byte(b3);    idle(gap);
        send_byte(b4);    idle(gap);
        send_byte(chk);
        check("commit_frame_ok", 32'(frame_ok), 32'(exp_ok));
        check("commit_frame_err", 32'(frame_err), 32'(!exp_ok));
        check("commit_ready_low", 32'(byte_ready), 32'd0);
        idle(1);
        check("after_wr_count", 32'(wr_count), 32'(exp_count));
        check("after_err_code", 32'(err_code), 32'(exp_code));
        check("after_pulses", {30'd0, frame_ok, frame_err}, 32'd0);
    endtask

    task automatic read_check(input string tag, input logic [3:0] addr, input logic [29:0] exp);
        rd_addr = addr;
        idle(1);
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic reset_check();
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_pulses", {30'd0, frame_ok, frame_err}, 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_ready", 32'(byte_ready), 32'd1);
    endtask

    initial begin
        rst        = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        rd_addr    = 4'd0;
        idle(2);
        reset_check();
        rst = 1'b1;
        idle(1);

        // Good frame: x=4 y=4 z=9
        send_frame(8'h00, 8'h40, 8'h10, 8'h09, 8'h59, 0, 1'b1, 2'b00, 5'd1);
        read_check("rd_entry0", 4'd0, 30'h00401009);

        // Bad checksum, then x=1000 out of range
        send_frame(8'h00, 8'h40, 8'h10, 8'h09, 8'h58, 0, 1'b0, 2'b01, 5'd1);
        send_frame(8'h3E, 8'h80, 8'h00, 8'h00, 8'hBE, 0, 1'b0, 2'b10, 5'd1);

        // Junk before header and valid gaps inside the frame; err_code holds at 10
        ready_base = ready_low;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_frame(8'h01, 8'h23, 8'h45, 8'h67, 8'h00, 2, 1'b1, 2'b10, 5'd2);
        check("gap_ready_low_cycles", 32'(ready_low - ready_base), 32'd1);
        read_check("rd_entry1", 4'd1, 30'h01234567);
        read_check("rd_entry0_again", 4'd0, 30'h00401009);

        // Reset in mid-frame, then a fresh good frame lands at address 0
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b0;
        idle(1);
        reset_check();
        rst = 1'b1;
        send_frame(8'h02, 8'hAB, 8'hCD, 8'h12, 8'h76, 0, 1'b1, 2'b00, 5'd1);
        read_check("rd_after_midreset", 4'd0, 30'h02ABCD12);

        // Fill the memory to 16 entries
        for (int i = 1; i < 16; i++) begin
            send_frame(8'h00, 8'h00, 8'h00, 8'(i), 8'(i), 0, 1'b1, 2'b00, 5'(i + 1));
            check("full_flag_progress", 32'(full), 32'(i == 15));
        end
        read_check("rd_entry15", 4'd15, 30'h0000000F);

        // 17th good frame is rejected as full; bad checksum still wins over full
        send_frame(8'h00, 8'h00, 8'h00, 8'h20, 8'h20, 0, 1'b0, 2'b11, 5'd16);
        send_frame(8'h00, 8'h00, 8'h00, 8'h20, 8'h21, 0, 1'b0, 2'b01, 5'd16);
        check("full_held", 32'(full), 32'd1);
        read_check("rd_entry0_unchanged", 4'd0, 30'h02ABCD12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/arm_position_writer.md
ARM_POSITION_WRITER -- requirements
Module: arm_position_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 30: stored position word width, {x[9:0], y[9:0], z[9:0]}.
REQ-002 Parameter ADDRESS_WIDTH, default 4: position memory depth is 2**ADDRESS_WIDTH entries.
REQ-003 Parameter HEADER, default 8'hA5: frame start byte.
REQ-004 Parameter MAX_COORD, default 999: largest legal x, y or z, matching the 3-digit display.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 byte_in  input  8  received byte.
REQ-008 byte_valid  input  1  byte_in is valid this cycle.
REQ-009 byte_ready  output  1  block accepts byte_in this cycle.
REQ-010 rd_addr  input  ADDRESS_WIDTH  playback read address.
REQ-011 rd_data  output  DATA_WIDTH  registered read data.
REQ-012 frame_ok  output  1  one-cycle pulse: frame committed.
REQ-013 frame_err  output  1  one-cycle pulse: frame rejected.
REQ-014 err_code  output  2  reason for the last rejection: 01 checksum, 10 range, 11 memory full; held until the next rejection.
REQ-015 wr_count  output  ADDRESS_WIDTH+1  number of stored entries.
REQ-016 full  output  1  high when wr_count equals 2**ADDRESS_WIDTH.

Function
REQ-017 A byte transfers only on a cycle where byte_valid and byte_ready are both high.
REQ-018 Frame format: HEADER, B1, B2, B3, B4, CHK; word = {B1[5:0], B2, B3, B4}; B1[7:6] ignored.
REQ-019 Field mapping: x = word[29:20], y = word[19:10], z = word[9:0].
REQ-020 Checksum rule: frame passes when CHK equals B1^B2^B3^B4.
REQ-021 FSM states: IDLE, DATA, CHECK, COMMIT.
REQ-022 IDLE: a transferred byte equal to HEADER moves the FSM to DATA with the byte index set to 0; any other byte is discarded.
REQ-023 DATA: each transfer shifts the byte into the word and increments the index; the fourth byte moves the FSM to CHECK; HEADER values are treated as plain data.
REQ-024 CHECK: the next transferred byte is latched as CHK and the FSM moves to COMMIT.
REQ-025 COMMIT lasts exactly one cycle with byte_ready low, then returns to IDLE; byte_ready is high in all other states.
REQ-026 COMMIT evaluates errors with priority checksum > range (any field > MAX_COORD) > full.
REQ-027 With no error, COMMIT writes the word to mem[wr_ptr], increments wr_ptr and wr_count, and pulses frame_ok.
REQ-028 With an error, COMMIT pulses frame_err, updates err_code, and leaves the memory, wr_ptr and wr_count unchanged.
REQ-029 When full is high, valid frames are still parsed but are rejected with code 11; the pointer does not wrap.
REQ-030 rd_data = mem[rd_addr] with 1-cycle latency; a read and a write to the same address in one cycle return the old data.
REQ-031 frame_ok and frame_err are never high in the same cycle.

Reset
REQ-032 While rst is low at a clock edge: FSM to IDLE, byte index 0, wr_ptr 0, wr_count 0, full 0, frame_ok 0, frame_err 0, err_code 00, rd_data 0.
REQ-033 Reset in mid-frame discards the partial frame; the first byte accepted after release is parsed in IDLE.
REQ-034 Memory contents are not cleared by reset.

Structure
REQ-035 A shared package holds the frame header, MAX_COORD, the err_code encodings and the FSM state encoding.
REQ-036 Storage is a single sub-module, position_ram: one write port, one registered read port, with no reset on the array.

Verification
REQ-037 Send A5 00 40 10 09 59 (word x=4, y=4, z=9) -> frame_ok on the COMMIT cycle, wr_count=1; rd_addr=0 gives 30'h00401009 one cycle later.
REQ-038 Send A5 00 40 10 09 58 -> frame_err, err_code=01, wr_count unchanged.
REQ-039 Send a frame with x=1000 (B1=3E, B2=80, B3=00, B4=00, CHK=BE) -> frame_err, err_code=10.
REQ-040 Send 16 good frames then a 17th good frame -> full=1 after the 16th; the 17th gives err_code=11; mem[0] is unchanged.
REQ-041 Drive rst low after B2, then send a complete good frame -> exactly one entry is stored, at address 0, with the new data.
REQ-042 Leading junk bytes 00 FF before A5, plus byte_valid gaps inside a frame -> frame decoded correctly; byte_ready is low only in COMMIT.
